// File: rtl/display_mux_7seg_n.sv
// N-digit multiplexed 7-segment driver: prescaled digit scan, hex decode,
// per-digit decimal point, PWM brightness with anti-ghost guard,
// leading-zero blanking and frame-aligned double-buffered loads.
module display_mux_7seg_n #(
    parameter int unsigned N_DIGITS         = 4,
    parameter int unsigned CLK_HZ           = 100000000,
    parameter int unsigned REFRESH_HZ       = 1000,
    parameter int unsigned BRIGHT_W         = 3,
    parameter int unsigned GUARD            = 4,
    parameter bit          SEG_ACTIVE_LOW   = 1'b1,
    parameter bit          DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   digits_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [7:0]              SEG,
    output logic [N_DIGITS-1:0]     DIGIT,
    output logic                    frame_tick
);

    localparam int unsigned SLOT = CLK_HZ / (REFRESH_HZ * N_DIGITS);
    localparam int unsigned STEP = SLOT >> BRIGHT_W;
    localparam int unsigned PW   = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int unsigned LW   = PW + 1;
    localparam int unsigned SW   = $clog2(N_DIGITS);
    localparam int unsigned DW   = 4 * N_DIGITS;

    localparam logic [7:0]          SEG_XOR = {8{SEG_ACTIVE_LOW}};
    localparam logic [N_DIGITS-1:0] DIG_XOR = {N_DIGITS{DIGIT_ACTIVE_LOW}};

    logic [PW-1:0]       r_presc;
    logic [SW-1:0]       r_slot;
    logic [DW-1:0]       r_pend_dig;
    logic [N_DIGITS-1:0] r_pend_dp;
    logic [DW-1:0]       r_act_dig;
    logic [N_DIGITS-1:0] r_act_dp;
    logic [7:0]          r_seg;
    logic [N_DIGITS-1:0] r_digit;
    logic                r_frame_tick;

    logic                w_presc_wrap;
    logic                w_slot_last;
    logic [DW-1:0]       w_src_dig;
    logic [N_DIGITS-1:0] w_src_dp;
    logic [DW-1:0]       w_cur_dig;
    logic [N_DIGITS-1:0] w_cur_dp;
    logic [LW-1:0]       w_limit;
    logic                w_lit;
    logic                w_lz_run;
    logic [N_DIGITS-1:0] w_lz;
    logic [3:0]          w_nib;
    logic                w_dp;
    logic                w_blank;
    logic [N_DIGITS-1:0] w_onehot;
    logic [7:0]          w_seg_on;
    logic [N_DIGITS-1:0] w_digit_on;

    // Hex nibble to active-high g..a segment pattern
    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    assign w_presc_wrap = (r_presc == PW'(SLOT - 1));
    assign w_slot_last  = (r_slot == SW'(N_DIGITS - 1));

    // Data a frame would start with: a load on the frame-start cycle wins over pending
    assign w_src_dig = load ? digits_in : r_pend_dig;
    assign w_src_dp  = load ? dp_in     : r_pend_dp;
    // On the frame-start cycle the new frame's data is used straight away so no slot tears
    assign w_cur_dig = r_frame_tick ? w_src_dig : r_act_dig;
    assign w_cur_dp  = r_frame_tick ? w_src_dp  : r_act_dp;

    assign w_limit = LW'(brightness) * LW'(STEP);

    // Prescaler and slot counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_slot  <= '0;
        end else if (w_presc_wrap) begin
            r_presc <= '0;
            r_slot  <= w_slot_last ? '0 : r_slot + SW'(1);
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    // Pending buffer takes every load; active buffer swaps only at frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend_dig <= '0;
            r_pend_dp  <= '0;
            r_act_dig  <= '0;
            r_act_dp   <= '0;
        end else begin
            if (load) begin
                r_pend_dig <= digits_in;
                r_pend_dp  <= dp_in;
            end
            if (r_frame_tick) begin
                r_act_dig <= w_src_dig;
                r_act_dp  <= w_src_dp;
            end
        end
    end

    // Select current digit, leading-zero blanking, brightness/guard window
    always_comb begin
        w_lz_run   = 1'b1;
        w_lz       = '0;
        w_nib      = 4'h0;
        w_dp       = 1'b0;
        w_blank    = 1'b0;
        w_onehot   = '0;
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            w_lz_run = w_lz_run && (w_cur_dig[4*i +: 4] == 4'h0);
            w_lz[i]  = w_lz_run;
        end
        for (int i = 0; i < int'(N_DIGITS); i++) begin
            if (r_slot == SW'(i)) begin
                w_nib       = w_cur_dig[4*i +: 4];
                w_dp        = w_cur_dp[i];
                w_blank     = blank_lz && (i != 0) && w_lz[i];
                w_onehot[i] = 1'b1;
            end
        end
        w_lit      = en && (r_presc >= PW'(GUARD)) && (LW'(r_presc) < w_limit);
        w_seg_on   = w_lit ? {w_dp, (w_blank ? 7'h00 : hex7(w_nib))} : 8'h00;
        w_digit_on = w_lit ? w_onehot : '0;
    end

    // Output registers; polarity applied only here
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg        <= SEG_XOR;
            r_digit      <= DIG_XOR;
            r_frame_tick <= 1'b0;
        end else begin
            r_seg        <= w_seg_on ^ SEG_XOR;
            r_digit      <= w_digit_on ^ DIG_XOR;
            r_frame_tick <= w_presc_wrap && w_slot_last;
        end
    end

    assign SEG        = r_seg;
    assign DIGIT      = r_digit;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_display_mux_7seg_n.sv
// Directed bench for display_mux_7seg_n (4 digits, SLOT=16, STEP=4, GUARD=1).
// Cycle k = number of clock edges since reset release; outputs seen at cycle k
// reflect prescaler/slot state of cycle k-1 (presc = (k-1)%16, slot = ((k-1)/16)%4).
module tb_display_mux_7seg_n;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic        blank_lz;
    logic [1:0]  brightness;
    logic [7:0]  SEG;
    logic [3:0]  DIGIT;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    display_mux_7seg_n #(
        .N_DIGITS(4), .CLK_HZ(64000), .REFRESH_HZ(1000), .BRIGHT_W(2),
        .GUARD(1), .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .digits_in(digits_in), .dp_in(dp_in), .blank_lz(blank_lz),
        .brightness(brightness), .SEG(SEG), .DIGIT(DIGIT), .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  dp;
        logic        blz;
        logic [1:0]  br;
        logic        en;
        int          k;
        logic [3:0]  xdig;
        logic [7:0]  xseg;
    } vec_t;

    vec_t vt [23];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic goto_cyc(input int k);
        if (cyc > k) begin
            total++;
            bad++;
            $display("FAIL goto: already at cycle %0d, target %0d", cyc, k);
        end
        while (cyc < k) tick();
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] dp);
        digits_in = d;
        dp_in     = dp;
        load      = 1'b1;
        tick();
        load      = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; load = 1'b0; digits_in = '0; dp_in = '0;
        blank_lz = 1'b0; brightness = '0;

        //           d        dp    blz   br    en    k    DIGIT  SEG
        vt[0]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 1'b1, 65,  4'hF, 8'hFF};
        vt[1]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 1'b1, 66,  4'hE, 8'h99};
        vt[2]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 1'b1, 76,  4'hE, 8'h99};
        vt[3]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 1'b1, 77,  4'hF, 8'hFF};
        vt[4]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 1'b1, 82,  4'hD, 8'hB0};
        vt[5]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 1'b1, 98,  4'hB, 8'hA4};
        vt[6]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 1'b1, 114, 4'h7, 8'hF9};
        vt[7]  = '{16'h1234, 4'h0, 1'b0, 2'd3, 1'b1, 2,   4'hE, 8'hC0};
        vt[8]  = '{16'h1234, 4'h0, 1'b0, 2'd1, 1'b1, 68,  4'hE, 8'h99};
        vt[9]  = '{16'h1234, 4'h0, 1'b0, 2'd1, 1'b1, 69,  4'hF, 8'hFF};
        vt[10] = '{16'h1234, 4'h0, 1'b0, 2'd0, 1'b1, 66,  4'hF, 8'hFF};
        vt[11] = '{16'h1234, 4'h0, 1'b0, 2'd3, 1'b0, 66,  4'hF, 8'hFF};
        vt[12] = '{16'h0050, 4'h8, 1'b1, 2'd3, 1'b1, 114, 4'h7, 8'h7F};
        vt[13] = '{16'h0050, 4'h8, 1'b1, 2'd3, 1'b1, 98,  4'hB, 8'hFF};
        vt[14] = '{16'h0050, 4'h8, 1'b1, 2'd3, 1'b1, 82,  4'hD, 8'h92};
        vt[15] = '{16'h0050, 4'h8, 1'b1, 2'd3, 1'b1, 66,  4'hE, 8'hC0};
        vt[16] = '{16'h0050, 4'h8, 1'b0, 2'd3, 1'b1, 114, 4'h7, 8'h40};
        vt[17] = '{16'hABCD, 4'h0, 1'b0, 2'd3, 1'b1, 66,  4'hE, 8'hA1};
        vt[18] = '{16'hABCD, 4'h0, 1'b0, 2'd3, 1'b1, 82,  4'hD, 8'hC6};
        vt[19] = '{16'hABCD, 4'h0, 1'b0, 2'd3, 1'b1, 98,  4'hB, 8'h83};
        vt[20] = '{16'hABCD, 4'h0, 1'b0, 2'd3, 1'b1, 114, 4'h7, 8'h88};
        vt[21] = '{16'h0000, 4'h0, 1'b1, 2'd3, 1'b1, 66,  4'hE, 8'hC0};
        vt[22] = '{16'h0000, 4'h0, 1'b1, 2'd3, 1'b1, 82,  4'hD, 8'hFF};

        // Reset values
        repeat (3) tick();
        chk("reset DIGIT", 16'(DIGIT), 16'h000F);
        chk("reset SEG", 16'(SEG), 16'h00FF);
        chk("reset frame_tick", 16'(frame_tick), 16'h0000);
        rst_n = 1'b1;
        cyc   = 0;

        // Table-driven scan vectors
        for (int i = 0; i < 23; i++) begin
            do_reset();
            blank_lz   = vt[i].blz;
            brightness = vt[i].br;
            en         = vt[i].en;
            load_word(vt[i].d, vt[i].dp);
            goto_cyc(vt[i].k);
            chk($sformatf("vec%0d DIGIT", i), 16'(DIGIT), 16'(vt[i].xdig));
            chk($sformatf("vec%0d SEG", i), 16'(SEG), 16'(vt[i].xseg));
        end

        // frame_tick timing and lit-cycle counts per slot
        do_reset();
        blank_lz = 1'b0; brightness = 2'd1; en = 1'b1;
        load_word(16'h1234, 4'h0);
        goto_cyc(63);
        chk("frame_tick@63", 16'(frame_tick), 16'h0000);
        tick();
        chk("frame_tick@64", 16'(frame_tick), 16'h0001);
        tick();
        chk("frame_tick@65", 16'(frame_tick), 16'h0000);
        goto_cyc(128);
        chk("frame_tick@128", 16'(frame_tick), 16'h0001);
        n = 0;
        for (int j = 0; j < 16; j++) begin
            tick();
            if (DIGIT != 4'hF) n++;
        end
        chk("lit cycles br1", 16'(n), 16'd3);
        brightness = 2'd0;
        n = 0;
        for (int j = 0; j < 64; j++) begin
            tick();
            if (DIGIT != 4'hF) n++;
        end
        chk("lit cycles br0", 16'(n), 16'd0);

        // Tear-free loading
        do_reset();
        blank_lz = 1'b0; brightness = 2'd3; en = 1'b1; dp_in = 4'h0;
        load_word(16'h1234, 4'h0);
        goto_cyc(101);
        load_word(16'hAAAA, 4'h0);
        goto_cyc(104);
        chk("tear slot2 DIGIT", 16'(DIGIT), 16'h000B);
        chk("tear slot2 SEG", 16'(SEG), 16'h00A4);
        goto_cyc(114);
        chk("tear slot3 SEG", 16'(SEG), 16'h00F9);
        goto_cyc(130);
        chk("new frame DIGIT", 16'(DIGIT), 16'h000E);
        chk("new frame SEG", 16'(SEG), 16'h0088);
        goto_cyc(192);
        chk("frame_tick@192", 16'(frame_tick), 16'h0001);
        load_word(16'h5555, 4'h0);
        goto_cyc(194);
        chk("coincident load SEG", 16'(SEG), 16'h0092);

        // Reset mid-frame
        goto_cyc(227);
        chk("pre-reset DIGIT", 16'(DIGIT), 16'h000B);
        chk("pre-reset SEG", 16'(SEG), 16'h0092);
        rst_n = 1'b0;
        tick();
        chk("midreset DIGIT", 16'(DIGIT), 16'h000F);
        chk("midreset SEG", 16'(SEG), 16'h00FF);
        chk("midreset frame_tick", 16'(frame_tick), 16'h0000);
        rst_n = 1'b1;
        cyc   = 0;
        goto_cyc(2);
        chk("post-reset DIGIT", 16'(DIGIT), 16'h000E);
        chk("post-reset SEG", 16'(SEG), 16'h00C0);
        goto_cyc(66);
        chk("post-reset frame1 SEG", 16'(SEG), 16'h00C0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
